// File: rtl/mem_beat_sequencer.sv
// mem_beat_sequencer: turns one core load/store request into 1..MAX_BEATS
// single-word SRAM accesses at consecutive (wrapping) word addresses.
// Loads gather the registered memory Q into a packed rdata vector.
// Optional build macro MEM_SEQ_ALIGN_CHK_EN: reject multi-beat requests whose
// base is not aligned to the next power of two >= beat count (done+err pulse).

// One rdata slot: holds the captured word until the next load refills it.
module mem_beat_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  // capture register, cleared by reset
  always_ff @(posedge clk) begin
    if (rst)      q <= '0;
    else if (cap) q <= d;
  end
endmodule

module mem_beat_sequencer #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 2,
  parameter int CNT_W     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req,
  input  logic                          we,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [CNT_W-1:0]              beats_m1,
  input  logic [MAX_BEATS*DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]             ReadDataMem,
  output logic                          CEN,
  output logic                          WEN,
  output logic                          OEN,
  output logic [ADDR_W-1:0]             A,
  output logic [DATA_W-1:0]             Data2Mem,
  output logic [MAX_BEATS*DATA_W-1:0]   rdata,
  output logic                          stall,
  output logic                          done,
  output logic                          err
);
  localparam int IDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] base;
    logic [IDX_W-1:0]  n_m1;   // clamped beat count minus one
  } req_t;

  state_t                             state, state_n;
  logic [IDX_W-1:0]                   cnt, cnt_n;
  req_t                               req_in, req_q;
  logic [MAX_BEATS-1:0][DATA_W-1:0]   wdata_q;
  logic [MAX_BEATS-1:0][DATA_W-1:0]   rdata_q;
  logic [MAX_BEATS-1:0]               cap_vec;
  logic                               cap_en;
  logic [IDX_W-1:0]                   cap_idx;
  logic                               accept;
  logic                               misalign;

  assign accept = (state == IDLE) && req && !rst;
  assign stall  = req & ~done;
  assign rdata  = rst ? '0 : rdata_q;

  // request as it would be latched: beat count clamped to MAX_BEATS
  always_comb begin
    req_in      = '0;
    req_in.we   = we;
    req_in.base = base_addr;
    if (32'(beats_m1) > 32'(MAX_BEATS - 1)) req_in.n_m1 = IDX_W'(MAX_BEATS - 1);
    else                                    req_in.n_m1 = IDX_W'(beats_m1);
  end

`ifdef MEM_SEQ_ALIGN_CHK_EN
  logic [ADDR_W-1:0] align_mask;
  logic              err_q;

  // low-bit mask of the next power of two >= N (zero for a single beat)
  always_comb begin
    align_mask = '0;
    for (int k = 0; k < IDX_W; k++)
      if (32'(align_mask) < 32'(req_in.n_m1)) align_mask = {align_mask[ADDR_W-2:0], 1'b1};
  end

  assign misalign = |(base_addr & align_mask);

  // remember whether the accepted request was rejected, for the done cycle
  always_ff @(posedge clk) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= misalign;
  end

  assign err = done & err_q;
`else
  assign misalign = 1'b0;
  assign err      = 1'b0;
`endif

  // state and beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // latch request and store data so in-flight access ignores input changes
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      req_q   <= req_in;
      wdata_q <= wdata;
    end
  end

  // next state, memory strobes and load-capture selection
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    CEN      = 1'b1;
    WEN      = 1'b1;
    OEN      = 1'b1;
    A        = '0;
    Data2Mem = '0;
    done     = 1'b0;
    cap_en   = 1'b0;
    cap_idx  = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req) begin
            cnt_n   = '0;
            state_n = misalign ? DONE : RUN;
          end
        end
        RUN: begin
          CEN      = 1'b0;
          WEN      = ~req_q.we;
          OEN      = req_q.we;
          A        = req_q.base + ADDR_W'(cnt);
          Data2Mem = wdata_q[cnt];
          // Q of the previous beat is valid now
          if (!req_q.we && (cnt != '0)) begin
            cap_en  = 1'b1;
            cap_idx = cnt - IDX_W'(1);
          end
          if (cnt == req_q.n_m1) state_n = req_q.we ? DONE : DRAIN;
          else                   cnt_n   = cnt + IDX_W'(1);
        end
        DRAIN: begin
          cap_en  = 1'b1;
          cap_idx = req_q.n_m1;
          state_n = DONE;
        end
        DONE: begin
          done    = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // rdata slot array
  for (genvar j = 0; j < MAX_BEATS; j++) begin : g_slot
    assign cap_vec[j] = cap_en && (cap_idx == IDX_W'(j));
    mem_beat_slot #(.DATA_W(DATA_W)) u_slot (
      .clk (clk),
      .rst (rst),
      .cap (cap_vec[j]),
      .d   (ReadDataMem),
      .q   (rdata_q[j])
    );
  end
endmodule

// File: tb/tb_mem_beat_sequencer.sv
// Bench for mem_beat_sequencer: directed cases plus randomized accesses,
// checked against a transaction-level model of beats, latency and memory.
module tb_mem_beat_sequencer;
  localparam int AW = 7, DW = 32, MB = 2, CW = 1;
  localparam int DEPTH = 1 << AW;

  logic                 clk = 1'b0, rst = 1'b1;
  logic                 req = 1'b0, we = 1'b0;
  logic [AW-1:0]        base_addr = '0;
  logic [CW-1:0]        beats_m1 = '0;
  logic [MB*DW-1:0]     wdata = '0;
  logic [DW-1:0]        ReadDataMem;
  logic                 CEN, WEN, OEN, stall, done, err;
  logic [AW-1:0]        A;
  logic [DW-1:0]        Data2Mem;
  logic [MB*DW-1:0]     rdata;

  int checks = 0, failures = 0;

  mem_beat_sequencer #(.ADDR_W(AW), .DATA_W(DW), .MAX_BEATS(MB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .base_addr(base_addr), .beats_m1(beats_m1),
    .wdata(wdata), .ReadDataMem(ReadDataMem), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A),
    .Data2Mem(Data2Mem), .rdata(rdata), .stall(stall), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // SRAM attached to the DUT: registered Q, write on CEN=WEN=0
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] rmem_q = '0;
  logic          mem_init = 1'b1;
  assign ReadDataMem = rmem_q;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hC0DE0000 | i;
    end else if (!CEN && !WEN) begin
      mem[A] <= Data2Mem;
    end
    if (!CEN && !OEN) rmem_q <= mem[A];
  end

  // reference view of memory and of rdata
  logic [DW-1:0]    ref_mem [0:DEPTH-1];
  logic [MB*DW-1:0] exp_rdata = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one complete access from the IDLE cycle to the done cycle
  task automatic access(input logic iwe, input logic [AW-1:0] ibase, input logic [CW-1:0] ibm1,
                        input logic [MB*DW-1:0] iwd);
    int n, p2, dcyc;
    bit mis;
    logic [MB*DW-1:0] erd;
    n = int'(ibm1) + 1;
    if (n > MB) n = MB;
    p2 = 1;
    while (p2 < n) p2 = p2 * 2;
    mis = 1'b0;
`ifdef MEM_SEQ_ALIGN_CHK_EN
    mis = (n > 1) && ((int'(ibase) % p2) != 0);
`endif
    dcyc = mis ? 1 : (iwe ? n + 1 : n + 2);
    @(negedge clk);
    req = 1'b1; we = iwe; base_addr = ibase; beats_m1 = ibm1; wdata = iwd;
    #1;
    check("idle_stall", stall, 1'b1);
    check("idle_cen", CEN, 1'b1);
    for (int c = 1; c <= dcyc; c++) begin
      @(negedge clk);
      if (!mis && c <= n) begin
        check("run_cen", CEN, 1'b0);
        check("run_wen", WEN, !iwe);
        check("run_oen", OEN, iwe);
        check("run_addr", A, (int'(ibase) + c - 1) % DEPTH);
        check("run_data", Data2Mem, iwd[(c-1)*DW +: DW]);
      end else begin
        check("off_strobes", {CEN, WEN, OEN}, 3'b111);
        check("off_addr", A, 0);
        check("off_data", Data2Mem, 0);
      end
      check("done", done, c == dcyc);
      check("err", err, mis && (c == dcyc));
      check("stall", stall, c != dcyc);
      if (c != dcyc) begin
        we = 1'($urandom); base_addr = AW'($urandom); beats_m1 = CW'($urandom);
        wdata = {$urandom, $urandom};
      end else begin
        req = 1'b0;
      end
    end
    req = 1'b0;
    if (done !== 1'b1)
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (done === 1'b1) break;
      end
    erd = exp_rdata;
    if (!mis) begin
      for (int i = 0; i < n; i++) begin
        if (iwe) ref_mem[(int'(ibase) + i) % DEPTH] = iwd[i*DW +: DW];
        else     erd[i*DW +: DW] = ref_mem[(int'(ibase) + i) % DEPTH];
      end
    end
    exp_rdata = erd;
    check("rdata", rdata, exp_rdata);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'hC0DE0000 | i;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_strobes", {CEN, WEN, OEN}, 3'b111);
    check("rst_addr", A, 0);
    check("rst_data", Data2Mem, 0);
    check("rst_rdata", rdata, 0);
    check("rst_done_err", {done, err}, 2'b00);
    rst = 1'b0; mem_init = 1'b0;
    @(negedge clk);

    // two-beat store
    access(1'b1, 7'h10, 1'b1, {32'hBBBBBBBB, 32'hAAAAAAAA});
    // store then load of known words
    access(1'b1, 7'h20, 1'b1, {32'h40000000, 32'h3F800000});
    access(1'b0, 7'h20, 1'b1, {$urandom, $urandom});
    check("load_known", rdata, 64'h40000000_3F800000);
    // wrap past top of address space
    access(1'b0, 7'h7F, 1'b1, {$urandom, $urandom});
    // unaligned two-beat load
    access(1'b0, 7'h11, 1'b1, {$urandom, $urandom});
    // single-beat store, back-to-back
    access(1'b1, 7'h05, 1'b0, {32'h11111111, 32'h22222222});
    access(1'b0, 7'h05, 1'b0, {$urandom, $urandom});

    // reset during beat 0 of a load aborts it
    @(negedge clk);
    req = 1'b1; we = 1'b0; base_addr = 7'h30; beats_m1 = 1'b1;
    @(negedge clk);
    check("abort_run_cen", CEN, 1'b0);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    check("abort_cen", CEN, 1'b1);
    check("abort_rdata", rdata, 0);
    check("abort_done", done, 1'b0);
    rst = 1'b0;
    exp_rdata = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_quiet", {done, CEN}, 2'b01);
    end
    access(1'b0, 7'h10, 1'b1, {$urandom, $urandom});

    // randomized accesses, some back-to-back, some with idle gaps
    for (int t = 0; t < 40; t++) begin
      logic [AW-1:0] b;
      b = (t % 7 == 0) ? 7'h7F : AW'($urandom);
      access(1'($urandom), b, CW'($urandom), {$urandom, $urandom});
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
